ahb_lite_sram_slave: RTL and testbench

- Parametrised AHB-Lite slave: on-chip SRAM behind the AHB-Lite bus, generalised in data width, depth and wait-state count.
- Adds pipelined address/data phase tracking, narrow (byte/halfword) transfers with byte-lane writes, programmable wait states and the two-cycle ERROR response.
- Sits behind the address decoder/mux as a standard AHB-Lite slave; also the default bus-functional target for the AHB-Lite verification environment.

---
 rtl/ahb_lite_sram_slave.sv | 156 +++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave
//   AHB-Lite slave wrapping an on-chip SRAM. It handles byte, halfword and
//   word (and dword when DATA_WIDTH=64) transfers with byte-lane writes. It
//   can insert WAIT_STATES HREADYOUT-low cycles per OKAY data phase, and it
//   gives the two-cycle ERROR response for out-of-range, oversize or
//   misaligned accesses.
// Ports
//   HCLK, HRESET      clock, synchronous active-high reset
//   HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HPROT, HMASTLOCK
//                     address-phase inputs (HBURST/HPROT/HMASTLOCK unused)
//   HWDATA            write data (data phase)
//   HREADY            bus-wide ready from the mux
//   HRDATA            read data, zero outside a read DATA cycle
//   HREADYOUT, HRESP  slave ready / response
module ahb_lite_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [1:0]            HTRANS,
  input  logic [3:0]            HPROT,
  input  logic                  HMASTLOCK,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] BYTE_RANGE = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);
  localparam logic [3:0] CNT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic             accept, addr_err;
  logic [2:0]       amask;
  logic [7:0]       szmask;
  logic [BYTES-1:0] be;
  logic [IDX_W-1:0] widx;
  logic             mem_we;

  // Ignored protocol inputs and address bits above the word index.
  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], addr_q};

  assign accept = HSEL && HREADY && HTRANS[1];

  // Error check on the live address phase; the low-bit mask grows with size.
  always_comb begin
    amask = 3'b000;
    case (HSIZE)
      3'd1:    amask = 3'b001;
      3'd2:    amask = 3'b011;
      3'd3:    amask = 3'b111;
      default: amask = 3'b000;
    endcase
    addr_err = ({1'b0, HADDR} >= BYTE_RANGE) || (HSIZE > 3'(OFF_W)) ||
               (|(HADDR[2:0] & amask));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1: state_d = S_ERR2;
      // IDLE, DATA and ERR2 all act as a pipelined address-phase slot.
      default: begin
        if (accept) begin
          addr_d  = HADDR;
          write_d = HWRITE;
          size_d  = HSIZE;
          cnt_d   = CNT_LOAD;
          if (addr_err)             state_d = S_ERR1;
          else if (WAIT_STATES > 0) state_d = S_WAIT;
          else                      state_d = S_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  // Lane enables: a size-wide run of ones shifted to the byte offset.
  always_comb begin
    szmask = 8'h01;
    case (size_q)
      3'd0:    szmask = 8'h01;
      3'd1:    szmask = 8'h03;
      3'd2:    szmask = 8'h0F;
      default: szmask = 8'hFF;
    endcase
  end

  for (genvar b = 0; b < BYTES; b++) begin : g_lane
    logic [7:0] sh;
    assign sh    = szmask << addr_q[OFF_W-1:0];
    assign be[b] = sh[b];
  end

  assign widx   = addr_q[OFF_W +: IDX_W];
  // Commit happens on the edge that closes DATA; a reset edge never commits.
  assign mem_we = (state_q == S_DATA) && write_q && !HRESET;

  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++)
        if (be[b]) mem[widx][8*b +: 8] <= HWDATA[8*b +: 8];
    end
  end

  assign HRDATA    = (state_q == S_DATA && !write_q) ? mem[widx] : '0;
  assign HREADYOUT = !(state_q == S_WAIT || state_q == S_ERR1);
  assign HRESP     = (state_q == S_ERR1 || state_q == S_ERR2);

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Two DUTs (WAIT_STATES 0 and 3) share one master. `sel` picks the target,
// and the other DUT sees HSEL low.
module tb_ahb_lite_sram_slave;
  logic        hclk = 0, hreset = 1, sel = 0, hsel = 0, hwrite = 0;
  logic [31:0] haddr = 0, hwdata = 0;
  logic [2:0]  hsize = 0, hburst = 0;
  logic [1:0]  htrans = 0;
  logic [31:0] rd0, rd3, hrdata;
  logic        ro0, ro3, rs0, rs3, hready, hresp;

  always #5 hclk = ~hclk;

  assign hready = sel ? ro3 : ro0;
  assign hrdata = sel ? rd3 : rd0;
  assign hresp  = sel ? rs3 : rs0;

  ahb_lite_sram_slave #(.WAIT_STATES(0)) u_dut0 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel && !sel), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HPROT(4'h3), .HMASTLOCK(1'b0),
    .HWDATA(hwdata), .HREADY(hready), .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0));

  ahb_lite_sram_slave #(.WAIT_STATES(3)) u_dut3 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel && sel), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HPROT(4'h3), .HMASTLOCK(1'b0),
    .HWDATA(hwdata), .HREADY(hready), .HRDATA(rd3), .HREADYOUT(ro3), .HRESP(rs3));

  int n_cmp = 0, n_bad = 0;

  // Transfer list, observed results and model expectations.
  int          q_n;
  logic        q_w [64], q_hs [64];
  logic [31:0] q_a [64], q_d [64];
  logic [2:0]  q_s [64];
  logic [1:0]  q_t [64];
  logic [31:0] r_rd [64], e_rd [64];
  logic        r_resp [64], e_resp [64], r_e1 [64], e_e1 [64];
  int          r_cyc [64], e_cyc [64];

  // Byte-addressed reference memory, one per DUT.
  logic [7:0] ref_m [2][4096];

  task automatic add(input logic w, input logic [31:0] a, input logic [2:0] s,
                     input logic [31:0] d, input logic [1:0] t, input logic hs);
    q_w[q_n] = w; q_a[q_n] = a; q_s[q_n] = s; q_d[q_n] = d; q_t[q_n] = t; q_hs[q_n] = hs;
    q_n++;
  endtask

  // Sequential model: each transfer sees all earlier ones fully applied.
  task automatic model_run();
    int d, ws;
    logic act, err;
    logic [31:0] a, wa;
    d  = sel ? 1 : 0;
    ws = sel ? 3 : 0;
    for (int i = 0; i < q_n; i++) begin
      a   = q_a[i];
      act = q_t[i][1] && q_hs[i];
      err = act && (a >= 32'h1000 || q_s[i] > 3'd2 || (a % (32'd1 << q_s[i])) != 0);
      e_e1[i]   = err;
      e_resp[i] = err;
      e_cyc[i]  = !act ? 1 : (err ? 2 : ws + 1);
      e_rd[i]   = 32'h0;
      if (act && !err) begin
        if (q_w[i]) begin
          for (int k = 0; k < (1 << q_s[i]); k++)
            ref_m[d][a + k] = q_d[i][8 * ((a + k) % 4) +: 8];
        end else begin
          wa = a & ~32'h3;
          e_rd[i] = {ref_m[d][wa+3], ref_m[d][wa+2], ref_m[d][wa+1], ref_m[d][wa]};
        end
      end
    end
  endtask

  // Pipelined master: next address phase overlaps the current data phase.
  task automatic run_seq(input string name);
    int ai = 0, di = -1, dcyc = 0, guard = 0;
    logic rdy, e1 = 0;
    for (int i = 0; i < 64; i++) begin r_rd[i] = 'x; r_resp[i] = 'x; r_e1[i] = 'x; r_cyc[i] = -1; end
    while ((ai < q_n || di >= 0) && guard < 400) begin
      guard++;
      if (ai < q_n) begin
        hsel = q_hs[ai]; htrans = q_t[ai]; haddr = q_a[ai]; hwrite = q_w[ai]; hsize = q_s[ai];
      end else begin
        hsel = 0; htrans = 2'b00; hwrite = 0;
      end
      hwdata = (di >= 0 && q_w[di]) ? q_d[di] : 32'h0;
      @(negedge hclk);
      rdy = hready;
      if (di >= 0) begin
        dcyc++;
        if (!rdy && hresp) e1 = 1;
        if (rdy) begin r_rd[di] = hrdata; r_resp[di] = hresp; r_e1[di] = e1; r_cyc[di] = dcyc; end
      end
      @(posedge hclk); #1;
      if (rdy) begin
        di = -1;
        if (ai < q_n) begin di = ai; ai++; dcyc = 0; e1 = 0; end
      end
    end
    if (guard >= 400) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: issued %0d of %0d, required completion within 400 cycles", name, ai, q_n);
    end
    hsel = 0; htrans = 2'b00; hwrite = 0; hwdata = 0;
  endtask

  task automatic test_reset_state();
    @(negedge hclk);
    n_cmp++;
    if ({ro0, rs0, rd0} !== {1'b1, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL reset_dut0: got rdy=%b resp=%b rdata=%h, want 1 0 0", ro0, rs0, rd0);
    end
    n_cmp++;
    if ({ro3, rs3, rd3} !== {1'b1, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL reset_dut3: got rdy=%b resp=%b rdata=%h, want 1 0 0", ro3, rs3, rd3);
    end
    @(posedge hclk); #1;
  endtask

  task automatic test_prefill(input logic s);
    sel = s; q_n = 0;
    for (int i = 0; i < 64; i++) add(1, 32'(i * 4), 3'd2, $urandom, 2'b10, 1);
    model_run(); run_seq("prefill");
    for (int i = 0; i < q_n; i++) begin
      n_cmp++;
      if ({r_rd[i], r_resp[i], r_e1[i], r_cyc[i]} !== {e_rd[i], e_resp[i], e_e1[i], e_cyc[i]}) begin
        n_bad++;
        $display("FAIL prefill[%0d]: got rd=%h resp=%b e1=%b cyc=%0d want rd=%h resp=%b e1=%b cyc=%0d",
                 i, r_rd[i], r_resp[i], r_e1[i], r_cyc[i], e_rd[i], e_resp[i], e_e1[i], e_cyc[i]);
      end
    end
  endtask

  task automatic test_word();
    sel = 0; q_n = 0;
    add(1, 32'h10, 3'd2, 32'hDEADBEEF, 2'b10, 1);
    add(0, 32'h10, 3'd2, 32'h0, 2'b10, 1);
    model_run(); run_seq("word");
    for (int i = 0; i < q_n; i++) begin
      n_cmp++;
      if ({r_rd[i], r_resp[i], r_e1[i], r_cyc[i]} !== {e_rd[i], e_resp[i], e_e1[i], e_cyc[i]}) begin
        n_bad++;
        $display("FAIL word[%0d]: got rd=%h resp=%b e1=%b cyc=%0d want rd=%h resp=%b e1=%b cyc=%0d",
                 i, r_rd[i], r_resp[i], r_e1[i], r_cyc[i], e_rd[i], e_resp[i], e_e1[i], e_cyc[i]);
      end
    end
    n_cmp++;
    if (r_rd[1] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL word_readback: got %h want deadbeef", r_rd[1]);
    end
  endtask

  task automatic test_byte_lanes();
    sel = 0; q_n = 0;
    add(1, 32'h10, 3'd2, 32'h00000000, 2'b10, 1);
    add(1, 32'h12, 3'd0, 32'hFFAAFFFF, 2'b10, 1);
    add(0, 32'h10, 3'd2, 32'h0, 2'b10, 1);
    add(1, 32'h10, 3'd1, 32'hEEEE1234, 2'b10, 1);
    add(0, 32'h10, 3'd2, 32'h0, 2'b10, 1);
    model_run(); run_seq("byte_lanes");
    for (int i = 0; i < q_n; i++) begin
      n_cmp++;
      if ({r_rd[i], r_resp[i], r_e1[i], r_cyc[i]} !== {e_rd[i], e_resp[i], e_e1[i], e_cyc[i]}) begin
        n_bad++;
        $display("FAIL byte_lanes[%0d]: got rd=%h resp=%b e1=%b cyc=%0d want rd=%h resp=%b e1=%b cyc=%0d",
                 i, r_rd[i], r_resp[i], r_e1[i], r_cyc[i], e_rd[i], e_resp[i], e_e1[i], e_cyc[i]);
      end
    end
    n_cmp++;
    if (r_rd[2] !== 32'h00AA0000) begin n_bad++; $display("FAIL byte_write: got %h want 00aa0000", r_rd[2]); end
    n_cmp++;
    if (r_rd[4] !== 32'h00AA1234) begin n_bad++; $display("FAIL half_write: got %h want 00aa1234", r_rd[4]); end
  endtask

  task automatic test_wait_states();
    int total;
    sel = 1; q_n = 0;
    add(0, 32'h20, 3'd2, 32'h0, 2'b10, 1);
    for (int i = 0; i < 8; i++) add(0, 32'(32'h40 + i * 4), 3'd2, 32'h0, (i == 0) ? 2'b10 : 2'b11, 1);
    hburst = 3'b101;
    model_run(); run_seq("wait_states");
    hburst = 3'b000;
    total = 0;
    for (int i = 0; i < q_n; i++) begin
      if (i > 0) total += r_cyc[i];
      n_cmp++;
      if ({r_rd[i], r_resp[i], r_e1[i], r_cyc[i]} !== {e_rd[i], e_resp[i], e_e1[i], e_cyc[i]}) begin
        n_bad++;
        $display("FAIL wait_states[%0d]: got rd=%h resp=%b e1=%b cyc=%0d want rd=%h resp=%b e1=%b cyc=%0d",
                 i, r_rd[i], r_resp[i], r_e1[i], r_cyc[i], e_rd[i], e_resp[i], e_e1[i], e_cyc[i]);
      end
    end
    n_cmp++;
    if (total != 32) begin n_bad++; $display("FAIL burst_cycles: got %0d want 32", total); end
  endtask

  task automatic test_errors();
    sel = 0; q_n = 0;
    add(0, 32'h1000, 3'd2, 32'h0, 2'b10, 1);
    add(1, 32'h11, 3'd1, 32'hFFFFFFFF, 2'b10, 1);
    add(0, 32'h10, 3'd2, 32'h0, 2'b10, 1);
    add(0, 32'h8, 3'd3, 32'h0, 2'b10, 1);
    add(0, 32'h10, 3'd2, 32'h0, 2'b10, 1);
    model_run(); run_seq("errors");
    for (int i = 0; i < q_n; i++) begin
      n_cmp++;
      if ({r_rd[i], r_resp[i], r_e1[i], r_cyc[i]} !== {e_rd[i], e_resp[i], e_e1[i], e_cyc[i]}) begin
        n_bad++;
        $display("FAIL errors[%0d]: got rd=%h resp=%b e1=%b cyc=%0d want rd=%h resp=%b e1=%b cyc=%0d",
                 i, r_rd[i], r_resp[i], r_e1[i], r_cyc[i], e_rd[i], e_resp[i], e_e1[i], e_cyc[i]);
      end
    end
    n_cmp++;
    if (r_rd[2] !== 32'h00AA1234) begin n_bad++; $display("FAIL err_no_write: got %h want 00aa1234", r_rd[2]); end
  endtask

  task automatic test_idle_busy();
    sel = 0; q_n = 0;
    add(1, 32'h10, 3'd2, 32'h11111111, 2'b01, 1);
    add(1, 32'h10, 3'd2, 32'h22222222, 2'b00, 1);
    add(1, 32'h10, 3'd2, 32'h33333333, 2'b10, 0);
    add(0, 32'h10, 3'd2, 32'h0, 2'b10, 1);
    model_run(); run_seq("idle_busy");
    for (int i = 0; i < q_n; i++) begin
      n_cmp++;
      if ({r_rd[i], r_resp[i], r_e1[i], r_cyc[i]} !== {e_rd[i], e_resp[i], e_e1[i], e_cyc[i]}) begin
        n_bad++;
        $display("FAIL idle_busy[%0d]: got rd=%h resp=%b e1=%b cyc=%0d want rd=%h resp=%b e1=%b cyc=%0d",
                 i, r_rd[i], r_resp[i], r_e1[i], r_cyc[i], e_rd[i], e_resp[i], e_e1[i], e_cyc[i]);
      end
    end
  endtask

  // Reset asserted for two edges while a write sits in its wait states.
  task automatic test_reset_mid_wait();
    sel = 1;
    hsel = 1; htrans = 2'b10; haddr = 32'h40; hwrite = 1; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel = 0; htrans = 2'b00; hwrite = 0; hwdata = 32'h55555555;
    @(negedge hclk);
    n_cmp++;
    if (hready !== 1'b0) begin n_bad++; $display("FAIL mid_wait: got ready=%b want 0", hready); end
    @(posedge hclk); #1;
    hreset = 1;
    repeat (2) @(posedge hclk);
    #1 hreset = 0; hwdata = 0;
    @(negedge hclk);
    n_cmp++;
    if ({ro3, rs3, rd3} !== {1'b1, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL reset_wait: got rdy=%b resp=%b rdata=%h, want 1 0 0", ro3, rs3, rd3);
    end
    @(posedge hclk); #1;
    q_n = 0;
    add(0, 32'h40, 3'd2, 32'h0, 2'b10, 1);
    model_run(); run_seq("reset_readback");
    n_cmp++;
    if ({r_rd[0], r_cyc[0]} !== {e_rd[0], e_cyc[0]}) begin
      n_bad++; $display("FAIL reset_abort: got rd=%h cyc=%0d want rd=%h cyc=%0d", r_rd[0], r_cyc[0], e_rd[0], e_cyc[0]);
    end
  endtask

  task automatic test_random(input logic s);
    int r;
    logic [2:0] sz;
    sel = s; q_n = 0;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      sz = 3'($urandom_range(0, 2));
      if (r == 0)      add($urandom_range(0, 1) != 0, 32'h10, 3'd2, $urandom, 2'($urandom_range(0, 1)), 1);
      else if (r == 1) add(1, 32'h20, 3'd2, $urandom, 2'b10, 0);
      else if (r == 2) add($urandom_range(0, 1) != 0, 32'(32'h1000 + 4 * $urandom_range(0, 255)), 3'd2, $urandom, 2'b10, 1);
      else if (r == 3) add($urandom_range(0, 1) != 0, 32'(2 * $urandom_range(0, 127) + 1), 3'($urandom_range(1, 3)), $urandom, 2'b10, 1);
      else add($urandom_range(0, 1) != 0, 32'($urandom_range(0, 255)) & ~((32'd1 << sz) - 1), sz, $urandom, 2'($urandom_range(2, 3)), 1);
    end
    model_run(); run_seq("random");
    for (int i = 0; i < q_n; i++) begin
      n_cmp++;
      if ({r_rd[i], r_resp[i], r_e1[i], r_cyc[i]} !== {e_rd[i], e_resp[i], e_e1[i], e_cyc[i]}) begin
        n_bad++;
        $display("FAIL random%0d[%0d]: a=%h s=%0d w=%b got rd=%h resp=%b e1=%b cyc=%0d want rd=%h resp=%b e1=%b cyc=%0d",
                 s, i, q_a[i], q_s[i], q_w[i], r_rd[i], r_resp[i], r_e1[i], r_cyc[i], e_rd[i], e_resp[i], e_e1[i], e_cyc[i]);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge hclk);
    #1 hreset = 0;
    test_reset_state();
    test_prefill(0);
    test_prefill(1);
    test_word();
    test_byte_lanes();
    test_wait_states();
    test_errors();
    test_idle_busy();
    test_reset_mid_wait();
    test_random(0);
    test_random(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
